// File: rtl/run_sequencer.sv
// Run controller for the 9-bit core: steps fetch -> execute -> optional load wait,
// owns the PC and the branch-target LUT, and gates decoder write enables.
module run_sequencer #(
    parameter int PC_W    = 10,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Req,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             CfgWe,
    input  logic [1:0]       CfgAddr,
    input  logic [PC_W-1:0]  CfgData,
    input  logic             Jump,
    input  logic             BranchEn,
    input  logic             RegWrEnD,
    input  logic             MemWrEnD,
    input  logic             LoadInst,
    input  logic             AckD,
    input  logic [1:0]       TargSel,
    input  logic             Cond,
    output logic [PC_W-1:0]  PC,
    output logic             ImemRd,
    output logic             RegWrEn,
    output logic             MemWrEn,
    output logic             MemRdEn,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEMWAIT,
        S_HALT
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(MEM_LAT - 1);

    state_t          state;
    state_t          state_next;
    logic [PC_W-1:0] lut [4];
    logic [PC_W-1:0] pc_next;
    logic [2:0]      wait_cnt;
    logic [2:0]      wait_next;
    logic            start_run;
    logic            lut_we;

    always_comb begin
        state_next = state;
        pc_next    = PC;
        wait_next  = wait_cnt;
        ImemRd     = 1'b0;
        RegWrEn    = 1'b0;
        MemWrEn    = 1'b0;
        MemRdEn    = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        start_run  = 1'b0;
        lut_we     = 1'b0;
        case (state)
            S_IDLE: begin
                lut_we = CfgWe;
                if (Req) begin
                    start_run  = 1'b1;
                    pc_next    = StartAddr;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                ImemRd     = 1'b1;
                Busy       = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                Busy = 1'b1;
                // Halt wins over load, and both suppress the decoder write enables.
                if (AckD) begin
                    state_next = S_HALT;
                end else if (LoadInst) begin
                    MemRdEn    = 1'b1;
                    wait_next  = WAIT_INIT;
                    state_next = S_MEMWAIT;
                end else begin
                    RegWrEn    = RegWrEnD;
                    MemWrEn    = MemWrEnD;
                    pc_next    = (BranchEn && Jump && Cond) ? lut[TargSel] : PC + PC_W'(1);
                    state_next = S_FETCH;
                end
            end
            S_MEMWAIT: begin
                Busy    = 1'b1;
                MemRdEn = 1'b1;
                if (wait_cnt != 3'd0) begin
                    wait_next = wait_cnt - 3'd1;
                end else begin
                    RegWrEn    = 1'b1;
                    pc_next    = PC + PC_W'(1);
                    state_next = S_FETCH;
                end
            end
            S_HALT: begin
                Done = 1'b1;
                if (!Req) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= S_IDLE;
            PC       <= '0;
            wait_cnt <= 3'd0;
            CycleCnt <= '0;
        end else begin
            state    <= state_next;
            PC       <= pc_next;
            wait_cnt <= wait_next;
            if (start_run) begin
                CycleCnt <= '0;
            end else if (Busy && (CycleCnt != '1)) begin
                CycleCnt <= CycleCnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 4; i++) begin
                lut[i] <= '0;
            end
        end else if (lut_we) begin
            lut[CfgAddr] <= CfgData;
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: an instruction-level model expands directed and random
// programs into per-cycle {stimulus, expected output} records that are replayed on the DUT.
module tb_run_sequencer;

    localparam int PC_W    = 10;
    localparam int MEM_LAT = 3;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             req;
    logic [PC_W-1:0]  start_addr;
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [PC_W-1:0]  cfg_data;
    logic             jump;
    logic             branch_en;
    logic             reg_wr_d;
    logic             mem_wr_d;
    logic             load_inst;
    logic             ack_d;
    logic [1:0]       targ_sel;
    logic             cond;
    logic [PC_W-1:0]  pc;
    logic             imem_rd;
    logic             reg_wr_en;
    logic             mem_wr_en;
    logic             mem_rd_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cycle_cnt;

    run_sequencer #(.PC_W(PC_W), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
        .Clk(clk), .Reset_n(rst_n), .Req(req), .StartAddr(start_addr),
        .CfgWe(cfg_we), .CfgAddr(cfg_addr), .CfgData(cfg_data),
        .Jump(jump), .BranchEn(branch_en), .RegWrEnD(reg_wr_d), .MemWrEnD(mem_wr_d),
        .LoadInst(load_inst), .AckD(ack_d), .TargSel(targ_sel), .Cond(cond),
        .PC(pc), .ImemRd(imem_rd), .RegWrEn(reg_wr_en), .MemWrEn(mem_wr_en),
        .MemRdEn(mem_rd_en), .Busy(busy), .Done(done), .CycleCnt(cycle_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic             req;
        logic [PC_W-1:0]  start;
        logic             cfg_we;
        logic [1:0]       cfg_addr;
        logic [PC_W-1:0]  cfg_data;
        logic             jump, branch_en, reg_wr_d, mem_wr_d, load_inst, ack_d;
        logic [1:0]       targ_sel;
        logic             cond;
        logic [PC_W-1:0]  e_pc;
        logic             e_imem, e_regwr, e_memwr, e_memrd, e_busy, e_done;
        logic [CNT_W-1:0] e_cnt;
        logic [7:0]       phase;
        int               run_id;
    } vec_t;

    // kind: 0 = ALU/store/branch, 1 = load, 2 = halt
    typedef struct {
        int       kind;
        bit       rw, mw, ben, jmp, cnd;
        bit [1:0] ts;
    } instr_t;

    vec_t   trace[$];
    instr_t prog[$];

    logic [PC_W-1:0] m_lut [4];
    logic [PC_W-1:0] m_pc;
    int              m_cnt;
    int              run_id;
    int              checks;
    int              errors;

    function automatic vec_t blank(logic [7:0] ph);
        vec_t v;
        v.req       = 1'($urandom_range(0, 1));
        v.start     = PC_W'($urandom);
        v.cfg_we    = 1'b1;
        v.cfg_addr  = 2'($urandom);
        v.cfg_data  = PC_W'($urandom);
        v.jump      = 1'($urandom_range(0, 1));
        v.branch_en = 1'($urandom_range(0, 1));
        v.reg_wr_d  = 1'($urandom_range(0, 1));
        v.mem_wr_d  = 1'($urandom_range(0, 1));
        v.load_inst = 1'($urandom_range(0, 1));
        v.ack_d     = 1'($urandom_range(0, 1));
        v.targ_sel  = 2'($urandom);
        v.cond      = 1'($urandom_range(0, 1));
        v.e_pc      = m_pc;
        v.e_imem    = 1'b0;
        v.e_regwr   = 1'b0;
        v.e_memwr   = 1'b0;
        v.e_memrd   = 1'b0;
        v.e_busy    = 1'b0;
        v.e_done    = 1'b0;
        v.e_cnt     = CNT_W'(m_cnt);
        v.phase     = ph;
        v.run_id    = run_id;
        return v;
    endfunction

    function automatic instr_t mk(int kind, bit rw, bit mw, bit ben, bit jmp, bit cnd, bit [1:0] ts);
        instr_t in;
        in.kind = kind; in.rw = rw; in.mw = mw; in.ben = ben;
        in.jmp = jmp; in.cnd = cnd; in.ts = ts;
        return in;
    endfunction

    task automatic bump_cnt();
        if (m_cnt < CNT_MAX) m_cnt++;
    endtask

    task automatic add_idle(bit we, bit [1:0] a, bit [PC_W-1:0] d);
        vec_t v;
        v = blank("I");
        v.req = 1'b0; v.cfg_we = we; v.cfg_addr = a; v.cfg_data = d;
        trace.push_back(v);
        if (we) m_lut[a] = d;
    endtask

    // Expands prog into cycles: start request, F/E per instruction, MEM_LAT waits per load, halt handshake.
    task automatic add_run(bit [PC_W-1:0] start, int hold, bit we, bit [1:0] a, bit [PC_W-1:0] d);
        vec_t v;
        run_id++;
        v = blank("I");
        v.req = 1'b1; v.start = start; v.cfg_we = we; v.cfg_addr = a; v.cfg_data = d;
        trace.push_back(v);
        if (we) m_lut[a] = d;
        m_pc  = start;
        m_cnt = 0;
        foreach (prog[k]) begin
            v = blank("F");
            v.e_imem = 1'b1; v.e_busy = 1'b1;
            trace.push_back(v);
            bump_cnt();
            v = blank("E");
            v.ack_d     = (prog[k].kind == 2);
            v.load_inst = (prog[k].kind == 1) ? 1'b1 : ((prog[k].kind == 2) ? v.load_inst : 1'b0);
            v.reg_wr_d  = prog[k].rw;
            v.mem_wr_d  = prog[k].mw;
            v.branch_en = prog[k].ben;
            v.jump      = prog[k].jmp;
            v.cond      = prog[k].cnd;
            v.targ_sel  = prog[k].ts;
            v.e_busy    = 1'b1;
            v.e_memrd   = (prog[k].kind == 1);
            if (prog[k].kind == 0) begin
                v.e_regwr = prog[k].rw;
                v.e_memwr = prog[k].mw;
            end
            trace.push_back(v);
            bump_cnt();
            if (prog[k].kind == 2) break;
            if (prog[k].kind == 1) begin
                for (int w = 0; w < MEM_LAT; w++) begin
                    v = blank("W");
                    v.e_busy = 1'b1; v.e_memrd = 1'b1; v.e_regwr = (w == MEM_LAT - 1);
                    trace.push_back(v);
                    bump_cnt();
                end
                m_pc = m_pc + PC_W'(1);
            end else if (prog[k].ben && prog[k].jmp && prog[k].cnd) begin
                m_pc = m_lut[prog[k].ts];
            end else begin
                m_pc = m_pc + PC_W'(1);
            end
        end
        for (int h = 0; h < hold; h++) begin
            v = blank("H");
            v.req = 1'b1; v.e_done = 1'b1;
            trace.push_back(v);
        end
        v = blank("H");
        v.req = 1'b0; v.e_done = 1'b1;
        trace.push_back(v);
    endtask

    task automatic apply_stimulus(vec_t v);
        req = v.req; start_addr = v.start;
        cfg_we = v.cfg_we; cfg_addr = v.cfg_addr; cfg_data = v.cfg_data;
        jump = v.jump; branch_en = v.branch_en; reg_wr_d = v.reg_wr_d;
        mem_wr_d = v.mem_wr_d; load_inst = v.load_inst; ack_d = v.ack_d;
        targ_sel = v.targ_sel; cond = v.cond;
    endtask

    task automatic check_output(vec_t v, int idx);
        checks++;
        if (pc !== v.e_pc || imem_rd !== v.e_imem || reg_wr_en !== v.e_regwr ||
            mem_wr_en !== v.e_memwr || mem_rd_en !== v.e_memrd || busy !== v.e_busy ||
            done !== v.e_done || cycle_cnt !== v.e_cnt) begin
            errors++;
            $display("[TB] FAIL vec%0d %s run%0d: got pc=%h imem=%b rw=%b mw=%b mr=%b busy=%b done=%b cnt=%0d, expected pc=%h imem=%b rw=%b mw=%b mr=%b busy=%b done=%b cnt=%0d",
                     idx, v.phase, v.run_id, pc, imem_rd, reg_wr_en, mem_wr_en, mem_rd_en,
                     busy, done, cycle_cnt, v.e_pc, v.e_imem, v.e_regwr, v.e_memwr,
                     v.e_memrd, v.e_busy, v.e_done, v.e_cnt);
        end
    endtask

    // Replays up to n queued records, one clock cycle each, then empties the queue.
    task automatic run_trace(int n);
        for (int i = 0; i < n && i < trace.size(); i++) begin
            apply_stimulus(trace[i]);
            @(negedge clk);
            check_output(trace[i], i);
            @(posedge clk);
            #1;
        end
        trace.delete();
    endtask

    task automatic model_reset();
        m_pc  = '0;
        m_cnt = 0;
        for (int i = 0; i < 4; i++) m_lut[i] = '0;
    endtask

    function automatic instr_t rand_instr();
        int r;
        r = $urandom_range(0, 9);
        return mk((r < 2) ? 1 : 0, 1'($urandom), 1'($urandom), (r > 6), 1'($urandom), 1'($urandom), 2'($urandom));
    endfunction

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;
        run_id = 0;
        model_reset();
        rst_n = 1'b0;
        v = blank("R");
        v.cfg_we = 1'b0; v.req = 1'b0;
        apply_stimulus(v);
        repeat (2) @(posedge clk);
        #1;
        check_output(v, -1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Straight-line run: two ALU writes then halt from address 5.
        add_idle(0, 0, 0);
        prog = '{mk(0, 1, 0, 0, 0, 0, 0), mk(0, 1, 0, 0, 0, 0, 0), mk(2, 1, 1, 0, 0, 0, 0)};
        add_run(10'd5, 0, 0, 0, 0);
        run_trace(trace.size());

        // Taken and not-taken branch through LUT[2].
        add_idle(1, 2'd2, 10'h3F0);
        prog = '{mk(0, 0, 0, 1, 1, 1, 2), mk(2, 0, 0, 0, 0, 0, 0)};
        add_run(10'd8, 0, 0, 0, 0);
        prog = '{mk(0, 1, 1, 1, 1, 0, 2), mk(2, 0, 0, 0, 0, 0, 0)};
        add_run(10'd8, 1, 0, 0, 0);
        run_trace(trace.size());

        // Load latency, PC wrap, then the LUT read back after CfgWe strobes during busy cycles.
        prog = '{mk(1, 1, 1, 1, 1, 1, 1), mk(2, 0, 0, 0, 0, 0, 0)};
        add_run(10'd4, 0, 0, 0, 0);
        prog = '{mk(0, 1, 0, 0, 0, 0, 0), mk(2, 0, 0, 0, 0, 0, 0)};
        add_run(10'h3FF, 0, 0, 0, 0);
        prog = '{mk(0, 0, 0, 1, 1, 1, 2), mk(2, 0, 0, 0, 0, 0, 0)};
        add_run(10'd20, 0, 0, 0, 0);
        run_trace(trace.size());

        // Req held through HALT, then restart combined with a same-cycle LUT write.
        prog = '{mk(0, 1, 0, 0, 0, 0, 0), mk(2, 0, 0, 0, 0, 0, 0)};
        add_run(10'd30, 10, 0, 0, 0);
        add_idle(0, 0, 0);
        prog = '{mk(0, 0, 0, 1, 1, 1, 3), mk(2, 0, 0, 0, 0, 0, 0)};
        add_run(10'd40, 0, 1, 2'd3, 10'h155);
        run_trace(trace.size());

        // Long run saturates the cycle counter.
        prog.delete();
        for (int k = 0; k < 10; k++) prog.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        prog.push_back(mk(2, 0, 0, 0, 0, 0, 0));
        add_run(10'd100, 2, 0, 0, 0);
        run_trace(trace.size());

        // Asynchronous reset in the middle of a load wait.
        prog = '{mk(1, 1, 0, 0, 0, 0, 0), mk(2, 0, 0, 0, 0, 0, 0)};
        add_run(10'd60, 0, 0, 0, 0);
        run_trace(5);
        #1;
        rst_n = 1'b0;
        model_reset();
        v = blank("R");
        #1;
        check_output(v, -2);
        @(posedge clk);
        #1;
        check_output(v, -3);
        v.req = 1'b0; v.cfg_we = 1'b0;
        apply_stimulus(v);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        add_idle(0, 0, 0);
        prog = '{mk(0, 0, 0, 1, 1, 1, 2), mk(2, 0, 0, 0, 0, 0, 0)};
        add_run(10'd70, 0, 0, 0, 0);
        run_trace(trace.size());

        // Random programs with random LUT contents and handshake timing.
        for (int r = 0; r < 25; r++) begin
            for (int i = $urandom_range(0, 2); i > 0; i--) begin
                add_idle(1'($urandom), 2'($urandom), PC_W'($urandom));
            end
            prog.delete();
            for (int k = $urandom_range(1, 6); k > 0; k--) prog.push_back(rand_instr());
            prog.push_back(mk(2, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom)));
            add_run(PC_W'($urandom), $urandom_range(0, 3), 1'($urandom), 2'($urandom), PC_W'($urandom));
            run_trace(trace.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
